// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// One outstanding access; stores complete in the grant cycle, reads wait MEM_LAT.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] if_hold_q, d_hold_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    owner_d   = owner_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = if_hold_q;
    d_rdata   = d_hold_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    stall     = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (if_req || d_req) begin
            mem_en = 1'b1;
            // data wins unless fetch has lost STARVE_MAX times in a row
            if (d_req && !(if_req && starve_q == STARVE_LIM)) begin
              d_gnt     = 1'b1;
              mem_we    = d_we;
              mem_addr  = d_addr;
              mem_wdata = d_wdata;
              if (!d_we) begin
                state_d = RD_WAIT;
                lat_d   = LAT_INIT;
                owner_d = 1'b1;
              end
            end else begin
              if_gnt   = 1'b1;
              mem_addr = if_addr;
              state_d  = RD_WAIT;
              lat_d    = LAT_INIT;
              owner_d  = 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (lat_q == 2'd0) begin
            state_d = IDLE;
            if (owner_q) begin
              d_rvalid = 1'b1;
              d_rdata  = mem_rdata;
            end else begin
              if_rvalid = 1'b1;
              if_rdata  = mem_rdata;
            end
          end else begin
            lat_d = lat_q - 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (!if_req || if_gnt) begin
        starve_d = 4'd0;
      end else if (d_gnt && starve_q != STARVE_LIM) begin
        starve_d = starve_q + 4'd1;
      end
      stall = (if_req && !if_rvalid)
            | (d_req && !d_we && !d_rvalid)
            | (d_req && d_we && !d_gnt);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= 2'd0;
      starve_q  <= 4'd0;
      owner_q   <= 1'b0;
      if_hold_q <= '0;
      d_hold_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      if (mem_en) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (if_rvalid) if_hold_q <= mem_rdata;
      if (d_rvalid)  d_hold_q  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed sequences then random traffic,
// checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int L    = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // reference model state
  bit          busy;
  int          ret_cyc;
  bit          owner_d;
  logic [31:0] raddr, ihold, dhold, last_addr, last_wd;
  int          starve;
  bit          e_ignt, e_dgnt;

  logic [31:0] due_addr [8];
  bit          due_v [8];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr,
                      input bit dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input bit rs);
    bit ret, free, issue, fwin, dwin, irv, drv, est;
    logic [31:0] ea, ewd, rd;
    @(posedge clk);
    #1;
    cyc++;
    reset = rs; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    mem_rdata = due_v[cyc % 8] ? memf(due_addr[cyc % 8]) : $urandom;
    due_v[cyc % 8] = 1'b0;
    @(negedge clk);
    if (rs) begin
      e_ignt = 0; e_dgnt = 0;
      busy = 0; starve = 0; ihold = '0; dhold = '0;
      last_addr = '0; last_wd = '0;
      chk("rst_if_gnt", if_gnt, 0);     chk("rst_d_gnt", d_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0); chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
      chk("rst_mem_en", mem_en, 0);     chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_stall", stall, 0);
      return;
    end
    ret   = busy && cyc == ret_cyc;
    free  = !busy;
    issue = free && (ir || dr);
    fwin  = issue && ir && (!dr || starve == SMAX);
    dwin  = issue && !fwin;
    ea    = fwin ? ia : (dwin ? da : last_addr);
    ewd   = dwin ? dwd : last_wd;
    irv   = ret && !owner_d;
    drv   = ret && owner_d;
    rd    = memf(raddr);
    est   = (ir && !irv) || (dr && !dwe && !drv) || (dr && dwe && !dwin);
    e_ignt = fwin; e_dgnt = dwin;
    chk("if_gnt", if_gnt, fwin);      chk("d_gnt", d_gnt, dwin);
    chk("mem_en", mem_en, issue);     chk("mem_we", mem_we, dwin && dwe);
    chk("mem_addr", mem_addr, ea);    chk("mem_wdata", mem_wdata, ewd);
    chk("if_rvalid", if_rvalid, irv); chk("d_rvalid", d_rvalid, drv);
    chk("if_rdata", if_rdata, irv ? rd : ihold);
    chk("d_rdata", d_rdata, drv ? rd : dhold);
    chk("stall", stall, est);
    if (mem_en) begin
      due_addr[(cyc + L) % 8] = mem_addr;
      due_v[(cyc + L) % 8] = 1'b1;
    end
    if (irv) ihold = rd;
    if (drv) dhold = rd;
    if (ret) busy = 0;
    if (issue && !(dwin && dwe)) begin
      busy = 1; ret_cyc = cyc + L; owner_d = dwin; raddr = ea;
    end
    last_addr = ea; last_wd = ewd;
    if (!ir || fwin) starve = 0;
    else if (dwin && starve < SMAX) starve++;
  endtask

  initial begin
    bit ir, dr, we, rs;
    logic [31:0] ia, da, wd, pc;
    ir = 0; dr = 0; we = 0; ia = '0; da = '0; wd = '0;
    repeat (2) step(0, 0, 0, 0, 0, 0, 1);
    // single fetch
    repeat (4) step(1, 32'h16c, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // fetch and load together; load goes first
    repeat (7) step(1, 32'h16c, 1, 0, 32'h100, 0, 0);
    // store
    step(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, 0);
    step(1, 32'h170, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    // continuous loads starve fetch
    repeat (24) step(1, 32'h174, 1, 0, 32'h104, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a read
    step(1, 32'h16c, 0, 0, 0, 0, 0);
    step(1, 32'h16c, 0, 0, 0, 0, 1);
    step(1, 32'h16c, 0, 0, 0, 0, 1);
    repeat (6) step(1, 32'h16c, 0, 0, 0, 0, 0);
    // back-to-back fetches
    pc = 32'h16c;
    repeat (10) begin
      step(1, pc, 0, 0, 0, 0, 0);
      if (e_ignt) pc += 32'd4;
    end
    // random traffic; second half biased toward data to force starvation
    for (int i = 0; i < 3000; i++) begin
      if (!(ir && !e_ignt) || $urandom_range(15) == 0) begin
        ir = (i >= 1500) || ($urandom_range(99) < 60);
        ia = 32'($urandom_range(1023)) << 2;
      end
      if (!(dr && !e_dgnt) || $urandom_range(15) == 0) begin
        dr = $urandom_range(99) < ((i >= 1500) ? 95 : 50);
        we = 1'($urandom_range(1));
        da = 32'($urandom_range(1023)) << 2;
        wd = $urandom;
      end
      rs = $urandom_range(199) == 0;
      step(ir, ia, dr, we, da, wd, rs);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
